hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It owns the enable and flush controls of the PC register, the IF/ID instruction register and the ID/EX register. It detects load-use hazards, taken-branch squashes and instruction-memory wait states. It resolves simultaneous events by fixed priority and counts lost cycles for performance monitoring.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles IF/ID is squashed after a taken branch (legal 1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_rs  in  `RSIZE  source register 1 of the instruction in ID.
- id_rt  in  `RSIZE  source register 2 of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads id_rt.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  `RSIZE  destination register of the EX instruction.
- br_taken  in  1  branch resolved taken in EX this cycle.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads NOP (0) instead of the fetched word.
- idex_bubble  out  1  ID/EX loads a bubble (all control bits 0).
- state  out  2  current FSM state, for debug.
- stall_cnt  out  CNT_W  cycles lost to load-use stalls plus imem waits.
- flush_cnt  out  CNT_W  cycles lost to branch squash.

## Operation
- States: RUN=0, FLUSH=1, IMEM_WAIT=2. Encoding 3 is illegal and returns to RUN on the next edge.
- Load-use hazard (LU) is true when all of these hold:
  - ex_memread=1;
  - ex_rd≠0;
  - ex_rd==id_rs, or (id_uses_rt and ex_rd==id_rt).
- Outputs are combinational from the state and the current inputs. The following list is in priority order; the first matching entry wins.
  1. br_taken (any state): pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. Squash counter loads FLUSH_CYCLES-1. Next state is FLUSH if FLUSH_CYCLES>1, else RUN. A branch in FLUSH restarts the squash.
  2. State FLUSH: pc_en=imem_ready, ifid_en=1, ifid_flush=1, idex_bubble=0. Counter decrements. Go to RUN when the counter reaches 0 and imem_ready=1. If the counter reaches 0 with imem_ready=0, go to IMEM_WAIT.
  3. LU (RUN only): pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1. Lasts exactly one cycle and the state stays RUN. The bubble clears LU on the next cycle.
  4. imem_ready=0 (RUN or IMEM_WAIT): pc_en=0, ifid_en=1, ifid_flush=1, idex_bubble=0. Next state is IMEM_WAIT.
  5. Otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0. IMEM_WAIT returns to RUN.
- A load-use hazard in IMEM_WAIT is not checked: ID already holds a NOP there.
- Counters:
  - stall_cnt increments on each cycle in which entry 3 or entry 4 applies.
  - flush_cnt increments on each cycle in which ifid_flush=1 because of entry 1 or 2.
  - Both saturate at all-ones and never wrap.
- Register-index compares use the full `RSIZE width. Register 0 never hazards.

## Timing
- Reset (rst=0, asynchronous):
  - state=RUN, squash counter=0, stall_cnt=0, flush_cnt=0;
  - outputs forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1 while rst is low.
- First edge after rst rises: normal RUN behaviour.
- Control latency is 0 cycles: outputs react in the same cycle as the inputs, and pipeline registers act on the next edge.
- A taken branch costs FLUSH_CYCLES squash cycles, plus any imem wait cycles.
- A load-use hazard costs exactly one stall cycle.
- Reset asserted mid-FLUSH discards the remaining squash immediately.
- Counter values update at the edge that ends the counted cycle.

## Structure
- `RSIZE (5) and `ISIZE belong in define.v next to the existing core widths.
- State encodings are `define constants in define.v.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, q) is instantiated twice for stall_cnt and flush_cnt.
- The hazard compare, FSM and output decode are flat in hazard_ctrl.

## Test plan
- Reset: hold rst=0 with random inputs → outputs 0,0,1,1, state=0, counters 0. Release → pc_en=1, ifid_en=1 with imem_ready=1.
- Load-use: ex_memread=1, ex_rd=5, id_rs=5 → one cycle of pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt=1. With ex_rd=0 → no stall.
- Branch, FLUSH_CYCLES=2: br_taken pulse → ifid_flush=1 for 2 cycles, state 0→1→0, flush_cnt=2.
- Simultaneous: br_taken=1 with LU true and imem_ready=0 → branch outputs win (pc_en=1, idex_bubble=1). No stall is counted.
- Imem wait: imem_ready=0 for 3 cycles → pc_en=0 and ifid_flush=1 for 3 cycles, stall_cnt=3, then RUN.
- Saturation: CNT_W=4, 20 stall cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, FSM state type and the load-use hazard compare for hazard_ctrl.
package hazard_ctrl_pkg;

  localparam int unsigned RSIZE = 5;
  localparam int unsigned ISIZE = 32;

  typedef logic [RSIZE-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    IMEM_WAIT = 2'd2
  } state_t;

  // Register 0 is hard-wired zero, so a load targeting it never hazards.
  function automatic logic load_use(input logic     memread,
                                    input reg_idx_t rd,
                                    input reg_idx_t rs,
                                    input reg_idx_t rt,
                                    input logic     uses_rt);
    return memread && (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and the register enable/flush controls.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_idx_t id_rs;
  reg_idx_t id_rt;
  logic     id_uses_rt;
  logic     ex_memread;
  reg_idx_t ex_rd;
  logic     br_taken;
  logic     imem_ready;
  logic     pc_en;
  logic     ifid_en;
  logic     ifid_flush;
  logic     idex_bubble;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, br_taken, imem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, br_taken, imem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the lost-cycle performance counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch squash and imem wait
// handling with fixed priority, plus lost-cycle counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] SQ_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     cur, nxt;
  logic [2:0] sq_cnt, sq_nxt;
  logic       lu;
  logic       pc_en_d, ifid_en_d, ifid_flush_d, idex_bubble_d;
  logic       stall_inc, flush_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur    <= RUN;
      sq_cnt <= '0;
    end else begin
      cur    <= nxt;
      sq_cnt <= sq_nxt;
    end
  end

  always_comb begin
    nxt           = cur;
    sq_nxt        = sq_cnt;
    pc_en_d       = 1'b1;
    ifid_en_d     = 1'b1;
    ifid_flush_d  = 1'b0;
    idex_bubble_d = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    lu            = load_use(hz.ex_memread, hz.ex_rd, hz.id_rs, hz.id_rt, hz.id_uses_rt);

    if (hz.br_taken) begin
      ifid_flush_d  = 1'b1;
      idex_bubble_d = 1'b1;
      flush_inc     = 1'b1;
      sq_nxt        = SQ_LOAD;
      nxt           = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      case (cur)
        FLUSH: begin
          pc_en_d      = hz.imem_ready;
          ifid_flush_d = 1'b1;
          flush_inc    = 1'b1;
          sq_nxt       = (sq_cnt != '0) ? sq_cnt - 3'd1 : '0;
          // The squash ends on the cycle the count steps from 1 to 0.
          if (sq_cnt <= 3'd1) begin
            nxt = hz.imem_ready ? RUN : IMEM_WAIT;
          end
        end
        RUN, IMEM_WAIT: begin
          if ((cur == RUN) && lu) begin
            pc_en_d       = 1'b0;
            ifid_en_d     = 1'b0;
            idex_bubble_d = 1'b1;
            stall_inc     = 1'b1;
          end else if (!hz.imem_ready) begin
            pc_en_d      = 1'b0;
            ifid_flush_d = 1'b1;
            stall_inc    = 1'b1;
            nxt          = IMEM_WAIT;
          end else begin
            nxt = RUN;
          end
        end
        default: nxt = RUN;
      endcase
    end
  end

  // Reset holds the pipeline frozen with NOPs regardless of the decode.
  assign hz.pc_en       = rst & pc_en_d;
  assign hz.ifid_en     = rst & ifid_en_d;
  assign hz.ifid_flush  = ~rst | ifid_flush_d;
  assign hz.idex_bubble = ~rst | idex_bubble_d;
  assign state          = cur;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: remaining squash cycles, waiting-for-imem flag, counts.
  int squash_left = 0;
  bit waiting     = 0;
  int stall_e     = 0;
  int flush_e     = 0;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (bus.slave),
    .state     (state),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat_inc(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ctrl_now();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble};
  endfunction

  // One cycle: drive inputs at the falling edge, check outputs, advance model.
  task automatic step(input logic br, input logic rdy, input logic mr, input logic ut,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    logic [3:0] exp_ctrl;
    logic [1:0] exp_state;
    bit         lu;
    bus.br_taken   = br;
    bus.imem_ready = rdy;
    bus.ex_memread = mr;
    bus.id_uses_rt = ut;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.ex_rd      = rd;
    #1;
    lu        = mr && (rd != 0) && ((rd == rs) || (ut && (rd == rt)));
    exp_state = (squash_left > 0) ? 2'd1 : (waiting ? 2'd2 : 2'd0);
    chk("state", 16'(state), 16'(exp_state));
    chk("stall_cnt", 16'(stall_cnt), 16'(stall_e));
    chk("flush_cnt", 16'(flush_cnt), 16'(flush_e));
    if (br) begin
      exp_ctrl    = 4'b1111;
      flush_e     = sat_inc(flush_e);
      squash_left = int'(FC) - 1;
      waiting     = 0;
    end else if (squash_left > 0) begin
      exp_ctrl    = {rdy, 3'b110};
      flush_e     = sat_inc(flush_e);
      squash_left = squash_left - 1;
      waiting     = (squash_left == 0) && !rdy;
    end else if (!waiting && lu) begin
      exp_ctrl = 4'b0001;
      stall_e  = sat_inc(stall_e);
    end else if (!rdy) begin
      exp_ctrl = 4'b0110;
      stall_e  = sat_inc(stall_e);
      waiting  = 1;
    end else begin
      exp_ctrl = 4'b1100;
      waiting  = 0;
    end
    chk("ctrl", 16'(ctrl_now()), 16'(exp_ctrl));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd_step();
    step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
         $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
  endtask

  // Asserts reset asynchronously (between edges), checks forced values, releases.
  task automatic do_reset();
    bus.br_taken   = $urandom_range(0, 1) == 1;
    bus.imem_ready = $urandom_range(0, 1) == 1;
    bus.ex_memread = 1'b1;
    bus.ex_rd      = 5'd5;
    bus.id_rs      = 5'd5;
    rst = 1'b0;
    #1;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_ctrl", 16'(ctrl_now()), 16'b0011);
    chk("rst_stall", 16'(stall_cnt), 16'd0);
    chk("rst_flush", 16'(flush_cnt), 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_ctrl", 16'(ctrl_now()), 16'b0011);
    rst = 1'b1;
    squash_left = 0;
    waiting     = 0;
    stall_e     = 0;
    flush_e     = 0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    bus.br_taken   = 1'b0;
    bus.imem_ready = 1'b1;
    bus.ex_memread = 1'b0;
    bus.id_uses_rt = 1'b0;
    bus.id_rs      = '0;
    bus.id_rt      = '0;
    bus.ex_rd      = '0;
    @(negedge clk);
    do_reset();

    // Normal run after reset release.
    step(0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
    // Load-use on rs, then the bubble clears it.
    step(0, 1, 1, 0, 5'd5, 5'd0, 5'd5);
    step(0, 1, 0, 0, 5'd5, 5'd0, 5'd5);
    chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
    // Register 0 never hazards; rt compare only when used.
    step(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    step(0, 1, 1, 1, 5'd1, 5'd7, 5'd7);
    step(0, 1, 1, 0, 5'd1, 5'd7, 5'd7);
    chk("rt_stall_cnt", 16'(stall_cnt), 16'd2);

    // Branch squash for FC cycles.
    do_reset();
    step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("br_flush_cnt", 16'(flush_cnt), 16'd2);

    // Branch beats load-use and imem wait; no stall counted.
    step(1, 0, 1, 0, 5'd5, 5'd0, 5'd5);
    chk("sim_stall_cnt", 16'(stall_cnt), 16'd0);
    // Squash ending with imem not ready enters IMEM_WAIT; LU ignored there.
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 1, 1, 0, 5'd6, 5'd0, 5'd6);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);

    // Imem wait for 3 cycles.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("imem_stall_cnt", 16'(stall_cnt), 16'd3);

    // Reset mid-flush discards the squash immediately.
    step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    do_reset();
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);

    // Saturation at 2^CW-1.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("sat_stall_cnt", 16'(stall_cnt), 16'(MAXC));

    // Randomized traffic with periodic resets so counters stay informative.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      for (int i = 0; i < 40; i++) rnd_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
